// File: rtl/agc_mem_sequencer.sv
// AGC memory-cycle sequencer: read into G, rewrite (edited) erasable word, return old contents.
// Fixed transaction of accept -> READ -> WRITE -> RESP; memory outputs decode from registered state only.
module agc_mem_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [11:0] req_addr,
  input  logic [14:0] req_wdata,
  output logic        rsp_valid,
  output logic [14:0] rsp_data,
  output logic        rsp_err,
  output logic [11:0] mem_addr,
  output logic [14:0] mem_wdata,
  output logic        mem_we,
  input  logic [14:0] mem_rdata
);

  localparam logic [11:0] ZERO_ADDR = 12'o0007;
  localparam logic [11:0] EDIT_BASE = 12'o0020;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [11:0] s_q, s_d;
  logic [14:0] w_q, w_d;
  logic        wr_q, wr_d;
  logic [14:0] g_q, g_d;
  logic [14:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic        is_zero;
  logic        is_erasable;
  logic        is_edit;
  logic [14:0] v_raw;
  logic [14:0] v_edit;

  assign is_zero     = (s_q == ZERO_ADDR);
  assign is_erasable = (s_q[11:10] == 2'b00);
  assign is_edit     = (s_q[11:2] == EDIT_BASE[11:2]);
  assign v_raw       = wr_q ? w_q : g_q;

  always_comb begin
    v_edit = v_raw;
    if (is_edit) begin
      case (s_q[1:0])
        2'd0:    v_edit = {v_raw[0], v_raw[14:1]};
        2'd1:    v_edit = {v_raw[14], v_raw[14:1]};
        2'd2:    v_edit = {v_raw[13:0], v_raw[14]};
        default: v_edit = {8'b0, v_raw[13:7]};
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    w_d        = w_q;
    wr_d       = wr_q;
    g_d        = g_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          s_d     = req_addr;
          w_d     = req_wdata;
          wr_d    = req_write;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        g_d     = is_zero ? 15'd0 : mem_rdata;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // Response registers hold until the next transaction reaches RESP.
        rsp_data_d = g_q;
        rsp_err_d  = wr_q & ~is_erasable;
        state_d    = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      s_q        <= 12'd0;
      w_q        <= 15'd0;
      wr_q       <= 1'b0;
      g_q        <= 15'd0;
      rsp_data_q <= 15'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      w_q        <= w_d;
      wr_q       <= wr_d;
      g_q        <= g_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = s_q;
  assign mem_we    = (state_q == ST_WRITE) & is_erasable & ~is_zero;
  assign mem_wdata = (state_q == ST_WRITE) ? v_edit : 15'd0;

endmodule

// File: tb/tb_agc_mem_sequencer.sv
// Bench for agc_mem_sequencer: behavioural memory + reference model, scoreboard queues, negedge monitor.
module tb_agc_mem_sequencer;

  localparam logic [11:0] ZERO_A = 12'o0007;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [11:0] req_addr;
  logic [14:0] req_wdata;
  logic        rsp_valid;
  logic [14:0] rsp_data;
  logic        rsp_err;
  logic [11:0] mem_addr;
  logic [14:0] mem_wdata;
  logic        mem_we;
  logic [14:0] mem_rdata;

  always #5 clk = ~clk;

  agc_mem_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  logic [14:0] mem     [4096];
  logic [14:0] ref_mem [4096];
  assign mem_rdata = mem[mem_addr];

  typedef struct packed { logic [14:0] data; logic err; int cyc; } rsp_t;
  typedef struct packed { logic [11:0] addr; logic [14:0] data; int cyc; } wr_t;
  rsp_t exp_rsp_q[$];
  wr_t  exp_wr_q[$];

  int          cyc;
  int          n_chk;
  int          n_fail;
  bit          mon_en;
  bit          b2b;
  int          b2b_prev;
  bit          have_last;
  logic [14:0] last_data;
  logic        last_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o expected %0o (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [14:0] edit_word(input logic [11:0] a, input logic [14:0] v);
    int x;
    x = int'(v);
    case (a)
      12'o0020: x = (x >> 1) | ((x & 1) << 14);
      12'o0021: x = (x >> 1) | (x & 'o40000);
      12'o0022: x = ((x << 1) & 'o77777) | (x >> 14);
      12'o0023: x = (x >> 7) & 'o177;
      default:  x = x;
    endcase
    return x[14:0];
  endfunction

  // Whole-transaction reference: old word out, edited word back to erasable (never the zero register).
  task automatic model(input bit wr, input logic [11:0] a, input logic [14:0] d, input int acc);
    logic [14:0] old;
    logic [14:0] v;
    bit          fixed;
    old   = (a == ZERO_A) ? 15'd0 : ref_mem[a];
    fixed = (a >= 12'd1024);
    v     = edit_word(a, wr ? d : old);
    if (!fixed && a != ZERO_A) begin
      ref_mem[a] = v;
      exp_wr_q.push_back('{addr: a, data: v, cyc: acc + 1});
    end
    exp_rsp_q.push_back('{data: old, err: (wr && fixed), cyc: acc + 2});
  endtask

  // Called at a negedge; leaves req_valid high after the accept edge.
  task automatic send(input bit wr, input logic [11:0] a, input logic [14:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      model(wr, a, d, cyc + 1);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_rsp_q.size() != 0 || exp_wr_q.size() != 0); i++) @(negedge clk);
    check("drain_rsp_left", exp_rsp_q.size(), 0);
    check("drain_wr_left", exp_wr_q.size(), 0);
  endtask

  initial begin
    logic [14:0] fixed_init;
    logic [14:0] prev300;
    int          mism;
    n_chk = 0; n_fail = 0; cyc = 0;
    mon_en = 1'b0; b2b = 1'b0; b2b_prev = -1; have_last = 1'b0;
    last_data = '0; last_err = 1'b0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 15'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[12'o0100] = 15'o12345; ref_mem[12'o0100] = 15'o12345;
    mem[12'o0200] = 15'o11111; ref_mem[12'o0200] = 15'o11111;
    mem[ZERO_A]   = 15'o55555; ref_mem[ZERO_A]   = 15'o55555;
    fixed_init = mem[12'o2000];

    fork
      forever begin
        @(posedge clk);
        cyc++;
        if (mem_we) mem[mem_addr] <= mem_wdata;
      end

      forever begin : monitor
        rsp_t e;
        wr_t  w;
        @(negedge clk);
        if (mon_en && rst_n) begin
          if (rsp_valid) begin
            if (exp_rsp_q.size() == 0) begin
              check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
              e = exp_rsp_q.pop_front();
              check("rsp_data", rsp_data, e.data);
              check("rsp_err", rsp_err, e.err);
              check("rsp_latency", cyc, e.cyc);
              if (b2b) begin
                if (b2b_prev >= 0) check("rsp_interval", cyc - b2b_prev, 4);
                b2b_prev = cyc;
              end
              last_data = e.data;
              last_err  = e.err;
              have_last = 1'b1;
            end
          end else if (have_last) begin
            check("rsp_hold_data", rsp_data, last_data);
            check("rsp_hold_err", rsp_err, last_err);
          end
          if (mem_we) begin
            if (exp_wr_q.size() == 0) begin
              check("unexpected_mem_we", {20'd0, mem_addr}, 32'hFFFF);
            end else begin
              w = exp_wr_q.pop_front();
              check("mem_addr", mem_addr, w.addr);
              check("mem_wdata", mem_wdata, w.data);
              check("mem_we_cycle", cyc, w.cyc);
            end
          end
        end
      end

      begin : stimulus
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_we", mem_we, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(2);

        send(0, 12'o0100, 15'o0);     idle(2);
        send(1, 12'o0200, 15'o07070); idle(1);
        send(0, 12'o0200, 15'o0);     idle(1);
        send(1, 12'o0020, 15'o00001); idle(1);
        send(1, 12'o0021, 15'o40000); idle(1);
        send(1, 12'o0022, 15'o40000); idle(1);
        send(1, 12'o0023, 15'o37600); idle(1);
        send(1, ZERO_A,   15'o77777); idle(1);
        send(0, ZERO_A,   15'o0);     idle(1);
        send(1, 12'o2000, 15'o12345); idle(1);
        send(0, 12'o2000, 15'o0);     idle(1);
        drain();
        check("mem_0100", mem[12'o0100], 15'o12345);
        check("mem_0200", mem[12'o0200], 15'o07070);
        check("mem_cyr", mem[12'o0020], 15'o40000);
        check("mem_sr", mem[12'o0021], 15'o60000);
        check("mem_cyl", mem[12'o0022], 15'o00001);
        check("mem_edop", mem[12'o0023], 15'o00177);
        check("mem_zero", mem[ZERO_A], 15'o55555);
        check("mem_fixed", mem[12'o2000], fixed_init);

        // Reset lands while the write cycle is on the memory bus.
        mon_en = 1'b0;
        prev300 = mem[12'o0300];
        send(1, 12'o0300, 15'o12121);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        check("reset_we_drop", mem_we, 0);
        check("reset_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rsp_q.delete();
        exp_wr_q.delete();
        ref_mem[12'o0300] = prev300;
        for (int i = 0; i < 4; i++) begin
          check("reset_no_rsp", rsp_valid, 0);
          @(negedge clk);
        end
        check("reset_mem_unchanged", mem[12'o0300], prev300);
        check("reset_ready_after", req_ready, 1);
        have_last = 1'b0;
        mon_en = 1'b1;

        b2b = 1'b1;
        b2b_prev = -1;
        for (int i = 0; i < 6; i++) send(0, 12'(12'o0400 + i), 15'o0);
        idle(0);
        drain();
        b2b = 1'b0;

        for (int n = 0; n < 200; n++) begin
          logic [11:0] a;
          case ($urandom_range(0, 9))
            0, 1:    a = 12'($urandom_range(0, 63));
            2:       a = 12'(12'o0020 + $urandom_range(0, 3));
            3:       a = ZERO_A;
            4, 5:    a = 12'($urandom_range(1024, 4095));
            default: a = 12'($urandom_range(0, 1023));
          endcase
          send($urandom_range(0, 1) == 1, a, 15'($urandom));
          if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
        end
        idle(0);
        drain();

        mism = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("mem_final_mismatches", mism, 0);
      end
    join_any

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
